// File: rtl/sb_pkg.sv
// sb_pkg: shared constants and helpers for the scoreboarded register file.
// Holds the default geometry (data width, register count, read-port count)
// and the ceiling-log2 helper that derives the address and counter widths.
package sb_pkg;

    localparam int SB_DATA_W = 16;
    localparam int SB_NREGS  = 16;
    localparam int SB_NRD    = 2;

    // Ceiling log2. The result is at least 1, so a degenerate size never
    // yields a zero-width vector.
    function automatic int sb_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_scoreboard.sv
// sb_scoreboard: pending-write tracking and hazard detection.
// Ports:
//   clk, clear             - clock and synchronous active-high reset
//   iss_valid/iss_rs/iss_rs_en/iss_rd/iss_wr - issue request
//   iss_ready              - no RAW or WAW hazard this cycle
//   wb_valid/wb_addr       - writeback strobe and target register
//   busy                   - per-register pending-write bit
//   pend_cnt               - population count of busy
//   wb_err                 - sticky: a writeback hit a register that was not busy
module sb_scoreboard
    import sb_pkg::*;
#(
    parameter int NREGS   = SB_NREGS,
    parameter int NRD     = SB_NRD,
    parameter int ZERO_R0 = 1,
    parameter int AW      = sb_clog2(NREGS),
    parameter int CW      = sb_clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              iss_valid,
    input  logic [NRD*AW-1:0] iss_rs,
    input  logic [NRD-1:0]    iss_rs_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic              iss_wr,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_addr,
    output logic [NREGS-1:0]  busy,
    output logic [CW-1:0]     pend_cnt,
    output logic              wb_err
);

    logic [NREGS-1:0] wb_clr;
    logic [NREGS-1:0] busy_eff;
    logic [NREGS-1:0] set_vec;
    logic             hazard;
    logic             accept_wr;
    logic             inc;
    logic             dec;
    logic             wb_r0;
    logic             rd_r0;

    always_comb begin
        wb_clr    = '0;
        set_vec   = '0;
        hazard    = 1'b0;
        accept_wr = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        wb_r0     = (ZERO_R0 != 0) && (wb_addr == '0);
        rd_r0     = (ZERO_R0 != 0) && (iss_rd == '0);

        if (wb_valid) begin
            wb_clr[wb_addr] = 1'b1;
        end
        // A register being written back this cycle no longer blocks issue.
        busy_eff = busy & ~wb_clr;

        for (int k = 0; k < NRD; k++) begin
            if (iss_rs_en[k] && busy_eff[iss_rs[k*AW +: AW]]) begin
                hazard = 1'b1;
            end
        end
        if (iss_wr && busy_eff[iss_rd]) begin
            hazard = 1'b1;
        end
        iss_ready = !hazard;

        // r0 in zero mode is never tracked, so an issue to it sets nothing.
        accept_wr = iss_valid && iss_ready && iss_wr && !rd_r0;
        if (accept_wr) begin
            set_vec[iss_rd] = 1'b1;
        end

        // A set never lands on an already-busy bit (that is a WAW hazard),
        // so inc/dec map one-to-one onto popcount changes, including the
        // same-register case where the bit stays set and the count holds.
        inc = accept_wr;
        dec = wb_valid && busy[wb_addr];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            busy     <= '0;
            pend_cnt <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy <= (busy & ~wb_clr) | set_vec;
            if (inc && !dec) begin
                pend_cnt <= pend_cnt + CW'(1);
            end else if (dec && !inc) begin
                pend_cnt <= pend_cnt - CW'(1);
            end
            if (wb_valid && !busy[wb_addr] && !wb_r0) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_reg_file.sv
// sb_reg_file: register file with write-through bypass and a scoreboard.
// Ports:
//   clk, clear             - clock and synchronous active-high reset
//   iss_valid/iss_rs/iss_rs_en/iss_rd/iss_wr - issue request
//   iss_ready              - issue accepted this cycle (no hazard)
//   rd_data                - combinational source operands, DATA_W per port
//   wb_valid/wb_addr/wb_data - writeback
//   busy, pend_cnt, wb_err - scoreboard state
//   dbg_addr/dbg_data      - combinational debug read of stored contents
module sb_reg_file
    import sb_pkg::*;
#(
    parameter int DATA_W  = SB_DATA_W,
    parameter int NREGS   = SB_NREGS,
    parameter int NRD     = SB_NRD,
    parameter int ZERO_R0 = 1,
    parameter int AW      = sb_clog2(NREGS),
    parameter int CW      = sb_clog2(NREGS + 1)
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  iss_valid,
    input  logic [NRD*AW-1:0]     iss_rs,
    input  logic [NRD-1:0]        iss_rs_en,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  iss_wr,
    output logic                  iss_ready,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [NREGS-1:0]      busy,
    output logic [CW-1:0]         pend_cnt,
    output logic                  wb_err,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     rs_addr;

    sb_scoreboard #(
        .NREGS   (NREGS),
        .NRD     (NRD),
        .ZERO_R0 (ZERO_R0),
        .AW      (AW),
        .CW      (CW)
    ) u_scoreboard (
        .clk       (clk),
        .clear     (clear),
        .iss_valid (iss_valid),
        .iss_rs    (iss_rs),
        .iss_rs_en (iss_rs_en),
        .iss_rd    (iss_rd),
        .iss_wr    (iss_wr),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .wb_err    (wb_err)
    );

    // Writes to r0 are dropped in zero mode; clear wipes every entry.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && !((ZERO_R0 != 0) && (wb_addr == '0))) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Source operands: hard zero for r0 in zero mode, then the in-flight
    // writeback data, then the stored value.
    always_comb begin
        rd_data = '0;
        rs_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            rs_addr = iss_rs[k*AW +: AW];
            if ((ZERO_R0 != 0) && (rs_addr == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (wb_valid && (wb_addr == rs_addr)) begin
                rd_data[k*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[rs_addr];
            end
        end
    end

    // Debug port shows stored contents only, without the bypass.
    always_comb begin
        dbg_data = regs[dbg_addr];
        if ((ZERO_R0 != 0) && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
    end

endmodule

// File: doc/sb_reg_file.md
SB_REG_FILE -- requirements
Module: sb_reg_file

Interface
Parameters
REQ-001 DATA_W, default 16: register width in bits.
REQ-002 NREGS, default 16: number of architectural registers; power of two, at least 4.
REQ-003 NRD, default 2: number of read ports, 1 to 4.
REQ-004 ZERO_R0, default 1: when 1, r0 reads 0, ignores writes and is never busy.
REQ-005 AW = log2(NREGS), derived; CW = log2(NREGS+1), derived.

Ports
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 clear  in  1  synchronous active-high reset.
REQ-009 iss_valid  in  1  an instruction is presented for issue.
REQ-010 iss_rs  in  NRD*AW  source addresses; port k occupies bits [k*AW +: AW].
REQ-011 iss_rs_en  in  NRD  per-port flag: the source is actually used.
REQ-012 iss_rd  in  AW  destination address.
REQ-013 iss_wr  in  1  the instruction writes iss_rd.
REQ-014 iss_ready  out  1  no hazard; the issue is accepted this cycle.
REQ-015 rd_data  out  NRD*DATA_W  combinational source operands.
REQ-016 wb_valid  in  1  writeback strobe.
REQ-017 wb_addr  in  AW  writeback address.
REQ-018 wb_data  in  DATA_W  writeback data.
REQ-019 busy  out  NREGS  pending-write bit per register.
REQ-020 pend_cnt  out  CW  population count of busy.
REQ-021 wb_err  out  1  sticky flag: a writeback hit a register that was not busy.
REQ-022 dbg_addr  in  AW  debug read address.
REQ-023 dbg_data  out  DATA_W  debug read data, combinational.

Function
REQ-024 rd_data[k] SHALL equal wb_data when wb_valid is high and wb_addr equals iss_rs[k] (write-through bypass); otherwise it SHALL equal the stored register value.
REQ-025 A source hazard SHALL exist on port k when iss_rs_en[k] is high, busy[iss_rs[k]] is high, and that register is not being cleared by a writeback in the same cycle.
REQ-026 A WAW hazard SHALL exist when iss_wr is high, busy[iss_rd] is high, and that register is not being cleared by a writeback in the same cycle.
REQ-027 iss_ready SHALL be high exactly when neither a source hazard nor a WAW hazard exists; it is independent of iss_valid.
REQ-028 An issue is accepted when iss_valid and iss_ready are both high; on acceptance with iss_wr high, busy[iss_rd] SHALL be set at the next edge.
REQ-029 On wb_valid, the register at wb_addr SHALL be written and busy[wb_addr] cleared at the next edge.
REQ-030 A simultaneous set and clear of the same busy bit SHALL leave the bit set, because the issuing instruction is the newer one.
REQ-031 pend_cnt SHALL update in the same edge as busy: +1, -1, or unchanged when a set and a clear coincide on different registers or on the same register.
REQ-032 wb_err SHALL be set at the next edge when wb_valid targets a register whose busy bit is low; the data is still written.
REQ-033 wb_err SHALL clear only on clear.
REQ-034 With ZERO_R0=1, for address 0: reads, bypass and dbg_data SHALL return 0; writes SHALL be dropped; busy[0] SHALL stay 0; wb_err SHALL NOT be raised.
REQ-035 Any number of read ports MAY address the same register, including iss_rd; all of them SHALL return identical data.

Reset
REQ-036 While clear is high at an edge, the block SHALL zero all registers, busy, pend_cnt and wb_err, and SHALL ignore issue and writeback in that cycle.
REQ-037 A clear asserted while writes are pending SHALL discard those writes; a later writeback to such a register SHALL set wb_err.
REQ-038 iss_ready SHALL be high in the first cycle after clear deasserts.

Structure
REQ-039 Package sb_pkg SHALL hold the default DATA_W/NREGS/NRD constants and the log2 helper used for AW and CW.
REQ-040 Sub-module sb_scoreboard SHALL own busy, pend_cnt, wb_err and the hazard logic.
REQ-041 sb_reg_file SHALL own the storage array and the bypass muxes.

Verification
REQ-042 After clear, write r3=0x1234 with no issue -> wb_err=1; next-cycle read of r3 = 0x1234.
REQ-043 Issue rd=5, then issue rs0=5 -> iss_ready=0 until the wb of r5=0xBEEF; in the wb cycle iss_ready=1 and rd_data[0]=0xBEEF.
REQ-044 Same-cycle issue rd=2 and wb r2 (r2 busy) -> busy[2] stays 1, pend_cnt unchanged.
REQ-045 Issue rd=0 and wb r0=0xFFFF with ZERO_R0=1 -> busy=0, r0 reads 0, wb_err=0.
REQ-046 Issue rd=1..15 back to back -> pend_cnt=15; assert clear -> busy=0, pend_cnt=0, all reads 0.
